// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencer for the arithmetic-encoder datapath: per-stage occupancy,
// load enables, issue-gap hazard spacing, whole-pipe backpressure, flush and drain.
module pipeline_seq_ctrl #(
   parameter int NUM_STAGES = 3,
   parameter int ISSUE_GAP  = 1,
   parameter int CNT_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  reset_ctrl,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  out_ready,
   input  logic                  flush,
   input  logic                  drain_req,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  out_valid,
   output logic [CNT_W-1:0]      occupancy,
   output logic                  busy,
   output logic                  drain_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [3:0] GAP_INIT = 4'(ISSUE_GAP);

   state_t                state, state_next;
   logic [NUM_STAGES-1:0] stage_valid, stage_valid_next;
   logic [3:0]            gap_cnt, gap_cnt_next;
   logic                  drain_prev;
   logic                  advance;
   logic                  accept;

   // The whole pipe stalls only when the final stage is held by downstream.
   assign advance  = !(stage_valid[NUM_STAGES-1] && !out_ready);
   assign in_ready = reset_ctrl && advance && (gap_cnt == 4'd0) && !drain_req
                     && !flush && (state != S_DRAIN);
   assign accept   = in_valid && in_ready;

   assign stage_en[0] = accept;
   generate
      for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_stage_en
         assign stage_en[gi] = advance && stage_valid[gi-1] && !flush;
      end
   endgenerate

   assign out_valid = stage_valid[NUM_STAGES-1];
   assign busy      = |stage_valid;

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         occupancy = occupancy + CNT_W'(stage_valid[i]);
      end
   end

   always_comb begin
      stage_valid_next = stage_valid;
      gap_cnt_next     = gap_cnt;
      if (flush) begin
         stage_valid_next = '0;
         gap_cnt_next     = 4'd0;
      end else begin
         if (advance) begin
            stage_valid_next = {stage_valid[NUM_STAGES-2:0], accept};
         end
         // Gap cycles are only consumed while the pipe is moving.
         if (accept) begin
            gap_cnt_next = GAP_INIT;
         end else if (advance && (gap_cnt != 4'd0)) begin
            gap_cnt_next = gap_cnt - 4'd1;
         end
      end
   end

   always_comb begin
      state_next = state;
      drain_done = 1'b0;
      case (state)
         S_IDLE: begin
            // An empty pipe completes a drain at once, once per request edge.
            drain_done = reset_ctrl && drain_req && !drain_prev;
            if (accept) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (drain_req) begin
               state_next = S_DRAIN;
            end else if (stage_valid_next == '0) begin
               state_next = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (stage_valid == '0) begin
               drain_done = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_ctrl) begin
      if (!reset_ctrl) begin
         stage_valid <= '0;
         gap_cnt     <= 4'd0;
         state       <= S_IDLE;
         drain_prev  <= 1'b0;
      end else begin
         stage_valid <= stage_valid_next;
         gap_cnt     <= gap_cnt_next;
         state       <= state_next;
         drain_prev  <= drain_req;
      end
   end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Bench for pipeline_seq_ctrl: two instances (3 stages/gap 1, 5 stages/gap 0),
// vector table, hand sequences and random traffic against a symbol-list model.
module tb_pipeline_seq_ctrl;

   localparam int NA = 3;
   localparam int GA = 1;
   localparam int NB = 5;
   localparam int GB = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] iv, ordy, fl, dr;

   logic          ir_a, ov_a, busy_a, dd_a;
   logic [NA-1:0] en_a;
   logic [1:0]    occ_a;
   logic          ir_b, ov_b, busy_b, dd_b;
   logic [NB-1:0] en_b;
   logic [2:0]    occ_b;

   pipeline_seq_ctrl #(.NUM_STAGES(NA), .ISSUE_GAP(GA)) dut_a (
      .clk(clk), .reset_ctrl(rst_n), .in_valid(iv[0]), .in_ready(ir_a),
      .out_ready(ordy[0]), .flush(fl[0]), .drain_req(dr[0]), .stage_en(en_a),
      .out_valid(ov_a), .occupancy(occ_a), .busy(busy_a), .drain_done(dd_a)
   );

   pipeline_seq_ctrl #(.NUM_STAGES(NB), .ISSUE_GAP(GB)) dut_b (
      .clk(clk), .reset_ctrl(rst_n), .in_valid(iv[1]), .in_ready(ir_b),
      .out_ready(ordy[1]), .flush(fl[1]), .drain_req(dr[1]), .stage_en(en_b),
      .out_valid(ov_b), .occupancy(occ_b), .busy(busy_b), .drain_done(dd_b)
   );

   // {in_ready, out_valid, busy, drain_done, occupancy[4:0], stage_en[15:0]}
   logic [24:0] act [2];
   logic [24:0] expv [2];
   always_comb begin
      act[0] = {ir_a, ov_a, busy_a, dd_a, 5'(occ_a), 16'(en_a)};
      act[1] = {ir_b, ov_b, busy_b, dd_b, 5'(occ_b), 16'(en_b)};
   end

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_assert++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, a, e);
      end
   endtask

   // Reference model: a list of in-flight symbols, each with its stage position.
   int  nsym [2];
   int  pos [2][16];
   int  gap [2];
   bit  draining [2];
   bit  prev_dr [2];
   bit  m_adv [2];
   bit  m_acc [2];

   function automatic int nst(input int d);
      return (d == 0) ? NA : NB;
   endfunction

   function automatic int gcfg(input int d);
      return (d == 0) ? GA : GB;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         nsym[d] = 0; gap[d] = 0; draining[d] = 0; prev_dr[d] = 0;
      end
   endtask

   task automatic model_eval();
      bit full, irdy, dd;
      logic [15:0] en;
      for (int d = 0; d < 2; d++) begin
         full = 0;
         for (int k = 0; k < nsym[d]; k++) if (pos[d][k] == nst(d) - 1) full = 1;
         m_adv[d] = !(full && !ordy[d]);
         irdy = rst_n && m_adv[d] && gap[d] == 0 && !dr[d] && !fl[d] && !draining[d];
         m_acc[d] = iv[d] && irdy;
         en = '0;
         en[0] = m_acc[d];
         if (m_adv[d] && !fl[d]) begin
            for (int k = 0; k < nsym[d]; k++)
               if (pos[d][k] < nst(d) - 1) en[pos[d][k] + 1] = 1'b1;
         end
         dd = rst_n && nsym[d] == 0 && (draining[d] || (dr[d] && !prev_dr[d]));
         expv[d] = {irdy, full, nsym[d] != 0, dd, 5'(nsym[d]), en};
      end
   endtask

   task automatic model_step();
      int  keep;
      bit  nxt_drain;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            nsym[d] = 0; gap[d] = 0; draining[d] = 0; prev_dr[d] = 0;
            continue;
         end
         nxt_drain = draining[d] ? (nsym[d] != 0) : ((nsym[d] != 0) && dr[d]);
         prev_dr[d] = dr[d];
         if (fl[d]) begin
            nsym[d] = 0;
            gap[d]  = 0;
         end else begin
            if (m_acc[d]) gap[d] = gcfg(d);
            else if (m_adv[d] && gap[d] > 0) gap[d] = gap[d] - 1;
            if (m_adv[d]) begin
               keep = 0;
               for (int k = 0; k < nsym[d]; k++) begin
                  if (pos[d][k] < nst(d) - 1) begin
                     pos[d][keep] = pos[d][k] + 1;
                     keep++;
                  end
               end
               nsym[d] = keep;
               if (m_acc[d]) begin
                  pos[d][nsym[d]] = 0;
                  nsym[d]++;
               end
            end
         end
         draining[d] = nxt_drain;
      end
   endtask

   task automatic tick_a();
      @(negedge clk);
      model_eval();
      chk($sformatf("model_a cyc %0d", cyc), 32'(act[0]), 32'(expv[0]));
      chk($sformatf("model_b cyc %0d", cyc), 32'(act[1]), 32'(expv[1]));
   endtask

   task automatic tick_b();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   typedef struct {
      logic       iv, ordy, fl, dr;
      logic       ir;
      logic [2:0] en;
      logic       ov;
      logic [1:0] occ;
      logic       dd;
   } vec_t;

   function automatic vec_t mk(input logic iv_, ordy_, fl_, dr_, ir_,
                               input logic [2:0] en_, input logic ov_,
                               input logic [1:0] occ_, input logic dd_);
      vec_t v;
      v.iv = iv_; v.ordy = ordy_; v.fl = fl_; v.dr = dr_; v.ir = ir_;
      v.en = en_; v.ov = ov_; v.occ = occ_; v.dd = dd_;
      return v;
   endfunction

   vec_t tbl [17];

   task automatic randomize_inputs();
      for (int d = 0; d < 2; d++) begin
         iv[d]   = ($urandom_range(0, 99) < 70);
         ordy[d] = ($urandom_range(0, 99) < 75);
         fl[d]   = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 4) dr[d] = ~dr[d];
      end
   endtask

   initial begin
      // warm-up, flush with occupancy 2 / gap 1, drain with 2 in flight, idle drain
      tbl[0]  = mk(1, 1, 0, 0, 1, 3'b001, 0, 2'd0, 0);
      tbl[1]  = mk(1, 1, 0, 0, 0, 3'b010, 0, 2'd1, 0);
      tbl[2]  = mk(1, 1, 0, 0, 1, 3'b101, 0, 2'd1, 0);
      tbl[3]  = mk(1, 1, 0, 0, 0, 3'b010, 1, 2'd2, 0);
      tbl[4]  = mk(1, 1, 0, 0, 1, 3'b101, 0, 2'd1, 0);
      tbl[5]  = mk(1, 1, 1, 0, 0, 3'b000, 1, 2'd2, 0);
      tbl[6]  = mk(1, 1, 0, 0, 1, 3'b001, 0, 2'd0, 0);
      tbl[7]  = mk(1, 1, 0, 0, 0, 3'b010, 0, 2'd1, 0);
      tbl[8]  = mk(1, 1, 0, 0, 1, 3'b101, 0, 2'd1, 0);
      tbl[9]  = mk(1, 1, 0, 1, 0, 3'b010, 1, 2'd2, 0);
      tbl[10] = mk(1, 1, 0, 1, 0, 3'b100, 0, 2'd1, 0);
      tbl[11] = mk(1, 1, 0, 1, 0, 3'b000, 1, 2'd1, 0);
      tbl[12] = mk(1, 1, 0, 1, 0, 3'b000, 0, 2'd0, 1);
      tbl[13] = mk(1, 1, 0, 1, 0, 3'b000, 0, 2'd0, 0);
      tbl[14] = mk(0, 1, 0, 0, 1, 3'b000, 0, 2'd0, 0);
      tbl[15] = mk(1, 1, 0, 1, 0, 3'b000, 0, 2'd0, 1);
      tbl[16] = mk(1, 1, 0, 1, 0, 3'b000, 0, 2'd0, 0);

      rst_n = 1'b0;
      iv = '0; ordy = '0; fl = '0; dr = '0;
      model_reset();
      @(posedge clk); #1;
      iv = 2'b11; ordy = 2'b11;
      tick_a();
      chk("reset_outputs_a", 32'(act[0]), 32'd0);
      chk("reset_outputs_b", 32'(act[1]), 32'd0);
      tick_b();
      rst_n = 1'b1;
      iv[1] = 1'b0;
      cyc = 0;

      for (int i = 0; i < 17; i++) begin
         iv[0] = tbl[i].iv; ordy[0] = tbl[i].ordy; fl[0] = tbl[i].fl; dr[0] = tbl[i].dr;
         tick_a();
         $display("row %0d: in_ready=%0b stage_en=%b out_valid=%0b occ=%0d drain_done=%0b",
                  i, ir_a, en_a, ov_a, occ_a, dd_a);
         chk($sformatf("tbl_in_ready row %0d", i), 32'(ir_a), 32'(tbl[i].ir));
         chk($sformatf("tbl_stage_en row %0d", i), 32'(en_a), 32'(tbl[i].en));
         chk($sformatf("tbl_out_valid row %0d", i), 32'(ov_a), 32'(tbl[i].ov));
         chk($sformatf("tbl_occupancy row %0d", i), 32'(occ_a), 32'(tbl[i].occ));
         chk($sformatf("tbl_busy row %0d", i), 32'(busy_a), 32'(tbl[i].occ != 2'd0));
         chk($sformatf("tbl_drain_done row %0d", i), 32'(dd_a), 32'(tbl[i].dd));
         tick_b();
      end
      iv[0] = 1'b0; dr[0] = 1'b0;

      // Full-throughput fill of the 5-stage instance, then a 3-cycle stall.
      iv[1] = 1'b1; ordy[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick_a();
         $display("fill b k=%0d: in_ready=%0b occ=%0d out_valid=%0b", k, ir_b, occ_b, ov_b);
         chk($sformatf("fill_in_ready k%0d", k), 32'(ir_b), 32'd1);
         chk($sformatf("fill_occupancy k%0d", k), 32'(occ_b), 32'((k < 5) ? k : 5));
         chk($sformatf("fill_out_valid k%0d", k), 32'(ov_b), 32'(k >= 5));
         tick_b();
      end
      ordy[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick_a();
         $display("stall b k=%0d: stage_en=%b in_ready=%0b occ=%0d", k, en_b, ir_b, occ_b);
         chk($sformatf("stall_stage_en k%0d", k), 32'(en_b), 32'd0);
         chk($sformatf("stall_in_ready k%0d", k), 32'(ir_b), 32'd0);
         chk($sformatf("stall_occupancy k%0d", k), 32'(occ_b), 32'd5);
         chk($sformatf("stall_out_valid k%0d", k), 32'(ov_b), 32'd1);
         tick_b();
      end
      ordy[1] = 1'b1;
      tick_a();
      $display("stall release b: stage_en=%b", en_b);
      chk("stall_release_stage_en", 32'(en_b), 32'h1f);
      tick_b();

      for (int k = 0; k < 700; k++) begin
         randomize_inputs();
         cycle_pair();
      end
      $display("random phase 1 done at cycle %0d", cyc);

      // Asynchronous reset in mid-cycle with traffic in flight.
      iv = 2'b11; ordy = 2'b11; fl = '0; dr = '0;
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: a=%h b=%h", act[0], act[1]);
      chk("async_reset_a", 32'(act[0]), 32'd0);
      chk("async_reset_b", 32'(act[1]), 32'd0);
      model_reset();
      cycle_pair();
      cycle_pair();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick_a();
         $display("rewarm a k=%0d: stage_en=%b", k, en_a);
         chk($sformatf("rewarm_stage_en k%0d", k), 32'(en_a),
             32'((k == 0) ? 3'b001 : (k == 1) ? 3'b010 : 3'b101));
         tick_b();
      end

      for (int k = 0; k < 500; k++) begin
         randomize_inputs();
         cycle_pair();
      end
      $display("random phase 2 done at cycle %0d", cyc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   task automatic cycle_pair();
      tick_a();
      tick_b();
   endtask

endmodule
